audio_sample_packet_decoder: RTL and testbench

- Receive-side counterpart of the HDMI audio sample packet builder. Takes decoded data-island packets (24-bit header plus four 56-bit subpackets) and keeps only Audio Sample packets (type 0x02, layout 0).
- Checks per-channel parity, re-assembles the 192-frame IEC60958 channel-status block, and streams stereo samples out through a small FIFO with a valid/ready handshake.
- Sits between the TMDS data-island depacketizer and the audio DAC/I2S serializer.

---
 rtl/audio_sample_packet_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_audio_sample_packet_decoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_packet_decoder.sv
// HDMI audio sample packet decoder: filters type-0x02 layout-0 packets,
// checks channel parity, rebuilds the IEC60958 channel-status block and
// streams stereo samples through a FWFT FIFO with valid/ready.
// Ports: clk_pixel, rst_n (async, active low); pkt_valid/pkt_ready,
// header[23:0], sub[223:0] in; sample_valid/sample_ready, sample_left,
// sample_right, sample_flags out; cs_block, cs_valid, cs_locked,
// parity_err_count status.
// Option: AUDIO_SAMPLE_PARITY_DROP_EN drops samples with a parity error.
module audio_sample_packet_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int CS_LENGTH  = 192
) (
  input  logic                 clk_pixel,
  input  logic                 rst_n,
  input  logic                 pkt_valid,
  output logic                 pkt_ready,
  input  logic [23:0]          header,
  input  logic [223:0]         sub,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic [23:0]          sample_left,
  output logic [23:0]          sample_right,
  output logic [7:0]           sample_flags,
  output logic [CS_LENGTH-1:0] cs_block,
  output logic                 cs_valid,
  output logic                 cs_locked,
  output logic [15:0]          parity_err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(CS_LENGTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [FW-1:0] LAST_FR = FW'(CS_LENGTH-1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]   state_q;
  logic [3:0]   pend_q;
  logic [3:0]   blk_q;
  logic [223:0] sub_q;

  logic [1:0]  idx;
  logic [55:0] cur;
  logic        par_l;
  logic        par_r;
  logic        b_cur;
  logic        drop;
  logic        full;
  logic        proc;
  logic        push;
  logic        pop;
  logic [3:0]  pend_d;
  logic [7:0]  flags;
  logic        accept;

  logic [55:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic [55:0]   head;

  logic [FW-1:0]        frame_q;
  logic [CS_LENGTH-1:0] shadow_q;
  logic [CS_LENGTH-1:0] shadow_d;
  logic [CS_LENGTH-1:0] cs_block_q;
  logic                 cs_valid_q;
  logic                 locked_q;
  logic [15:0]          err_q;
  logic [16:0]          err_d;

  logic unused_hdr;
  assign unused_hdr = ^header[19:13];

  // lowest pending subpacket goes first
  always_comb begin
    idx = 2'd0;
    if (pend_q[0])      idx = 2'd0;
    else if (pend_q[1]) idx = 2'd1;
    else if (pend_q[2]) idx = 2'd2;
    else if (pend_q[3]) idx = 2'd3;
  end

  assign cur    = sub_q[int'(idx)*56 +: 56];
  assign par_l  = ^{cur[51:48], cur[23:0]};
  assign par_r  = ^{cur[55:52], cur[47:24]};
  assign b_cur  = blk_q[idx];
  assign flags  = {par_r, par_l, cur[54], cur[50],
                   cur[53], cur[49], cur[52], cur[48]};
  assign pend_d = pend_q & ~(4'b0001 << idx);

`ifdef AUDIO_SAMPLE_PARITY_DROP_EN
  assign drop = par_l | par_r;
`else
  assign drop = 1'b0;
`endif

  assign full   = (cnt_q == FULL_CNT);
  // a dropped sample needs no FIFO space, so it never stalls
  assign proc   = (state_q == S_DRAIN) && (drop || !full);
  assign push   = proc && !drop;
  assign pop    = sample_valid && sample_ready;
  assign accept = pkt_valid && (header[7:0] == 8'h02) && !header[12];

  assign pkt_ready = (state_q == S_IDLE);

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      blk_q   <= '0;
      sub_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept && |header[11:8]) begin
            state_q <= S_DRAIN;
            pend_q  <= header[11:8];
            blk_q   <= header[23:20];
            sub_q   <= sub;
          end
        end
        S_DRAIN: begin
          if (proc) begin
            pend_q <= pend_d;
            if (pend_d == 4'd0) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (push) mem[wr_q] <= {cur[23:0], cur[47:24], flags};
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head         = mem[rd_q];
  assign sample_valid = (cnt_q != '0);
  assign sample_left  = sample_valid ? head[55:32] : 24'd0;
  assign sample_right = sample_valid ? head[31:8]  : 24'd0;
  assign sample_flags = sample_valid ? head[7:0]   : 8'd0;

  // completed block includes the bit arriving on the final frame
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[CS_LENGTH-1] = cur[50];
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      frame_q    <= '0;
      shadow_q   <= '0;
      cs_block_q <= '0;
      cs_valid_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      cs_valid_q <= 1'b0;
      if (proc) begin
        if (b_cur) begin
          frame_q     <= FW'(1);
          shadow_q[0] <= cur[50];
          locked_q    <= 1'b1;
        end else if (locked_q) begin
          if (frame_q == '0) begin
            locked_q <= 1'b0;
          end else if (frame_q == LAST_FR) begin
            cs_block_q <= shadow_d;
            cs_valid_q <= 1'b1;
            frame_q    <= '0;
          end else begin
            shadow_q[frame_q] <= cur[50];
            frame_q <= frame_q + 1'b1;
          end
        end
      end
    end
  end

  assign cs_block  = cs_block_q;
  assign cs_valid  = cs_valid_q;
  assign cs_locked = locked_q;

  assign err_d = {1'b0, err_q} + 17'(par_l) + 17'(par_r);

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (proc) begin
      err_q <= err_d[16] ? 16'hFFFF : err_d[15:0];
    end
  end

  assign parity_err_count = err_q;

endmodule

// File: tb/tb_audio_sample_packet_decoder.sv
// Scoreboard bench for audio_sample_packet_decoder.
// Directed packets; a negedge monitor pops and compares FIFO output.
module tb_audio_sample_packet_decoder;

  logic         clk_pixel = 1'b0;
  logic         rst_n = 1'b0;
  logic         pkt_valid = 1'b0;
  logic         pkt_ready;
  logic [23:0]  header = '0;
  logic [223:0] sub = '0;
  logic         sample_valid;
  logic         sample_ready = 1'b0;
  logic [23:0]  sample_left;
  logic [23:0]  sample_right;
  logic [7:0]   sample_flags;
  logic [191:0] cs_block;
  logic         cs_valid;
  logic         cs_locked;
  logic [15:0]  parity_err_count;

  always #5 clk_pixel = ~clk_pixel;

  audio_sample_packet_decoder dut (
    .clk_pixel(clk_pixel),
    .rst_n(rst_n),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .header(header),
    .sub(sub),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_left(sample_left),
    .sample_right(sample_right),
    .sample_flags(sample_flags),
    .cs_block(cs_block),
    .cs_valid(cs_valid),
    .cs_locked(cs_locked),
    .parity_err_count(parity_err_count)
  );

  logic [55:0] sb [$];
  int checks = 0;
  int errors = 0;
  int cs_pulses = 0;
  int exp_err = 0;
  logic [7:0] pat = 8'hA5;
  logic [223:0] subs;
  logic [191:0] cs_exp;

  function automatic logic [55:0] mk(
    input logic [23:0] l, input logic [23:0] r,
    input logic vl, input logic ul, input logic cl,
    input logic vr, input logic ur, input logic cr);
    logic [55:0] s;
    s = '0;
    s[23:0] = l;
    s[47:24] = r;
    s[48] = vl; s[49] = ul; s[50] = cl;
    s[52] = vr; s[53] = ur; s[54] = cr;
    s[51] = ^{cl, ul, vl, l};
    s[55] = ^{cr, ur, vr, r};
    return s;
  endfunction

  function automatic logic [223:0] mk_pkt(
    input logic [23:0] base, input logic [3:0] flg);
    logic [223:0] p;
    logic [23:0] l;
    for (int i = 0; i < 4; i++) begin
      l = base + 24'(i) * 24'h010101;
      p[i*56 +: 56] = mk(l, l ^ 24'h5A5A5A, flg[0], flg[1],
                         flg[2], flg[3], flg[0], flg[1]);
    end
    return p;
  endfunction

  function automatic logic [55:0] exp_of(input logic [55:0] s);
    logic pl;
    logic pr;
    pl = ^{s[51:48], s[23:0]};
    pr = ^{s[55:52], s[47:24]};
    return {s[23:0], s[47:24], pr, pl, s[54], s[50],
            s[53], s[49], s[52], s[48]};
  endfunction

  task automatic chk(input string name, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_pixel);
    #1;
  endtask

  task automatic send(input logic [23:0] h, input logic [223:0] p);
    int n;
    logic [55:0] s;
    logic pl;
    logic pr;
    n = 0;
    while (!pkt_ready && n < 300) begin
      tick(1);
      n++;
    end
    if (!pkt_ready) begin
      checks++;
      errors++;
      $display("FAIL pkt_ready_timeout got 0 want 1");
      return;
    end
    header = h;
    sub = p;
    pkt_valid = 1'b1;
    tick(1);
    pkt_valid = 1'b0;
    if (h[7:0] == 8'h02 && !h[12]) begin
      for (int i = 0; i < 4; i++) begin
        if (h[8+i]) begin
          s = p[i*56 +: 56];
          pl = ^{s[51:48], s[23:0]};
          pr = ^{s[55:52], s[47:24]};
          exp_err += int'(pl) + int'(pr);
`ifdef AUDIO_SAMPLE_PARITY_DROP_EN
          if (!(pl || pr)) sb.push_back(exp_of(s));
`else
          sb.push_back(exp_of(s));
`endif
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    tick(3);
    chk({name, "_left"}, 256'(sb.size()), 256'd0);
    chk({name, "_empty"}, 256'(sample_valid), 256'd0);
  endtask

  always @(negedge clk_pixel) begin
    if (rst_n && cs_valid) cs_pulses++;
    if (rst_n && sample_valid && sample_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL extra_sample got %h_%h_%h want none",
                 sample_left, sample_right, sample_flags);
      end else begin
        logic [55:0] e;
        e = sb.pop_front();
        if ({sample_left, sample_right, sample_flags} !== e) begin
          errors++;
          $display("FAIL sample got %h_%h_%h want %h_%h_%h",
                   sample_left, sample_right, sample_flags,
                   e[55:32], e[31:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    int lowc;
    int f;
    tick(3);
    chk("rst_ready", 256'(pkt_ready), 256'd1);
    chk("rst_valid", 256'(sample_valid), 256'd0);
    chk("rst_left", 256'(sample_left), 256'd0);
    chk("rst_lock", 256'(cs_locked), 256'd0);
    chk("rst_csblk", 256'(cs_block), 256'd0);
    chk("rst_errcnt", 256'(parity_err_count), 256'd0);
    rst_n = 1'b1;
    tick(1);

    // four present samples, flags clear
    sample_ready = 1'b1;
    send(24'h000F02, mk_pkt(24'h123450, 4'h0));
    lowc = 0;
    for (int k = 0; k < 20; k++) begin
      if (!pkt_ready) lowc++;
      tick(1);
    end
    chk("ready_low_cycles", 256'(lowc), 256'd4);
    wait_drain("basic");

    // 192 frames, B on first, C_L = 0xA5 repeated
    for (int p = 0; p < 48; p++) begin
      for (int i = 0; i < 4; i++) begin
        f = p * 4 + i;
        subs[i*56 +: 56] = mk(24'(f), ~24'(f), f[0], f[1],
                              pat[f % 8], f[2], 1'b0, f[3]);
      end
      send((p == 0) ? 24'h100F02 : 24'h000F02, subs);
    end
    wait_drain("cs");
    cs_exp = {24{8'hA5}};
    chk("cs_pulses", 256'(cs_pulses), 256'd1);
    chk("cs_block", 256'(cs_block), 256'(cs_exp));
    chk("cs_locked", 256'(cs_locked), 256'd1);

    // frame after wrap lacks B
    send(24'h000102, mk_pkt(24'h0F0F00, 4'h0));
    wait_drain("missb");
    chk("missb_lock", 256'(cs_locked), 256'd0);
    chk("missb_blk", 256'(cs_block), 256'(cs_exp));
    chk("missb_pulses", 256'(cs_pulses), 256'd1);

    // B mid-block re-syncs without a pulse
    send(24'h100F02, mk_pkt(24'h010000, 4'h4));
    send(24'h100F02, mk_pkt(24'h020000, 4'h0));
    wait_drain("resync");
    chk("resync_lock", 256'(cs_locked), 256'd1);
    chk("resync_pulses", 256'(cs_pulses), 256'd1);

    // bit 3 of L flipped in subpacket 1
    subs = mk_pkt(24'h345678, 4'hA);
    subs[56+3] = ~subs[56+3];
    send(24'h000F02, subs);
    wait_drain("parity");
    chk("parity_cnt", 256'(parity_err_count), 256'd1);
    chk("parity_model", 256'(exp_err), 256'd1);

    // backpressure: three packets into an 8-deep FIFO
    sample_ready = 1'b0;
    send(24'h000F02, mk_pkt(24'hA00000, 4'h1));
    send(24'h000F02, mk_pkt(24'hB00000, 4'h2));
    send(24'h000F02, mk_pkt(24'hC00000, 4'h3));
    tick(10);
    chk("bp_ready", 256'(pkt_ready), 256'd0);
    chk("bp_valid", 256'(sample_valid), 256'd1);
    sample_ready = 1'b1;
    wait_drain("bp");

    // wrong type and wrong layout, bad parity inside
    subs = mk_pkt(24'h777777, 4'h0);
    subs[0] = ~subs[0];
    send(24'h000F84, subs);
    send(24'h001F02, subs);
    tick(5);
    chk("bad_valid", 256'(sample_valid), 256'd0);
    chk("bad_errcnt", 256'(parity_err_count), 256'd1);
    chk("bad_ready", 256'(pkt_ready), 256'd1);
    chk("bad_sb", 256'(sb.size()), 256'd0);

    // reset while draining
    sample_ready = 1'b0;
    send(24'h000F02, mk_pkt(24'hD00000, 4'h5));
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mrst_valid", 256'(sample_valid), 256'd0);
    chk("mrst_left", 256'(sample_left), 256'd0);
    chk("mrst_flags", 256'(sample_flags), 256'd0);
    chk("mrst_ready", 256'(pkt_ready), 256'd1);
    chk("mrst_lock", 256'(cs_locked), 256'd0);
    chk("mrst_csblk", 256'(cs_block), 256'd0);
    chk("mrst_csv", 256'(cs_valid), 256'd0);
    chk("mrst_errcnt", 256'(parity_err_count), 256'd0);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    chk("post_valid", 256'(sample_valid), 256'd0);
    chk("post_ready", 256'(pkt_ready), 256'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
